// File: rtl/svc_sync_fifo_lvl.sv
// Single-clock first-word-fall-through FIFO with arbitrary depth, occupancy count,
// programmable almost-full/almost-empty levels, synchronous flush and sticky error flags.
module svc_sync_fifo_lvl #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  w_inc,
   input  logic [DATA_WIDTH-1:0] w_data,
   output logic                  w_full,
   input  logic                  r_inc,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  r_empty,
   output logic [CNT_WIDTH-1:0]  count,
   input  logic [CNT_WIDTH-1:0]  af_thresh,
   input  logic [CNT_WIDTH-1:0]  ae_thresh,
   output logic                  almost_full,
   output logic                  almost_empty,
   input  logic                  err_clr,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int ADDR_WIDTH = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  wr_ok;
   logic                  rd_ok;

   // Wrap on an explicit compare so non-power-of-two depths work.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
      if (a == ADDR_WIDTH'(DEPTH - 1))
         return '0;
      else
         return a + 1'b1;
   endfunction

   assign w_full       = (count == CNT_WIDTH'(DEPTH));
   assign r_empty      = (count == '0);
   assign wr_ok        = w_inc && !w_full;
   assign rd_ok        = r_inc && !r_empty;
   assign r_data       = mem[r_addr];
   assign almost_full  = (count >= af_thresh);
   assign almost_empty = (count <= ae_thresh);

   // Storage is data only: never reset, and a flush suppresses the write.
   always_ff @(posedge clk) begin
      if (wr_ok && !flush)
         mem[w_addr] <= w_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_addr <= '0;
         r_addr <= '0;
         count  <= '0;
      end else if (flush) begin
         w_addr <= '0;
         r_addr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok)
            w_addr <= next_addr(w_addr);
         if (rd_ok)
            r_addr <= next_addr(r_addr);
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // A new error in the same cycle as err_clr takes precedence over the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_inc && w_full && !flush)
            overflow <= 1'b1;
         else if (err_clr)
            overflow <= 1'b0;
         if (r_inc && r_empty && !flush)
            underflow <= 1'b1;
         else if (err_clr)
            underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_svc_sync_fifo_lvl.sv
// Directed bench for svc_sync_fifo_lvl at DEPTH=5 with hand-computed expectations.
module tb_svc_sync_fifo_lvl;

   localparam int DEPTH = 5;
   localparam int DW    = 8;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          w_inc;
   logic [DW-1:0] w_data;
   logic          w_full;
   logic          r_inc;
   logic [DW-1:0] r_data;
   logic          r_empty;
   logic [CW-1:0] count;
   logic [CW-1:0] af_thresh;
   logic [CW-1:0] ae_thresh;
   logic          almost_full;
   logic          almost_empty;
   logic          err_clr;
   logic          overflow;
   logic          underflow;

   int n_checks = 0;
   int n_pass   = 0;

   svc_sync_fifo_lvl #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .w_inc(w_inc), .w_data(w_data), .w_full(w_full),
      .r_inc(r_inc), .r_data(r_data), .r_empty(r_empty),
      .count(count), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      w_inc = 1'b1; w_data = d;
      step();
      w_inc = 1'b0;
   endtask

   task automatic pop(input string tag, input logic [DW-1:0] exp);
      check(tag, 32'(r_data), 32'(exp));
      r_inc = 1'b1;
      step();
      r_inc = 1'b0;
   endtask

   task automatic chk_lvl(input string tag, input int k);
      check({tag, "_cnt"}, 32'(count), 32'(k));
      check({tag, "_af"},  32'(almost_full),  32'(k >= int'(af_thresh)));
      check({tag, "_ae"},  32'(almost_empty), 32'(k <= int'(ae_thresh)));
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; w_inc = 1'b0; w_data = '0; r_inc = 1'b0;
      err_clr = 1'b0; af_thresh = 3'd4; ae_thresh = 3'd1;
      #1;
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(r_empty), 1);
      check("rst_full", 32'(w_full), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_udf", 32'(underflow), 0);
      check("rst_ae", 32'(almost_empty), 1);
      check("rst_af", 32'(almost_full), 0);
      af_thresh = 3'd0;
      #1;
      check("af_zero", 32'(almost_full), 1);
      af_thresh = 3'd4;
      #10 rst_n = 1'b1;

      // fill 1..5 with level flags at every occupancy
      chk_lvl("lvl0", 0);
      for (int i = 1; i <= 5; i++) begin
         push(DW'(i));
         chk_lvl($sformatf("lvl%0d", i), i);
         check("fwft_head", 32'(r_data), 1);
      end
      check("full", 32'(w_full), 1);
      push(8'd6);
      check("ovf_set", 32'(overflow), 1);
      check("ovf_cnt", 32'(count), 5);
      for (int i = 1; i <= 5; i++) pop($sformatf("rd%0d", i), DW'(i));
      check("drained_empty", 32'(r_empty), 1);
      check("ovf_sticky", 32'(overflow), 1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      check("ovf_clr", 32'(overflow), 0);

      // address wrap: 4 rounds of 3 writes / 3 reads
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 3; i++) begin
            push(DW'(8'h10 + r * 3 + i));
            check($sformatf("wrap_cnt_w%0d_%0d", r, i), 32'(count), 32'(i + 1));
         end
         for (int i = 0; i < 3; i++)
            pop($sformatf("wrap_rd%0d_%0d", r, i), DW'(8'h10 + r * 3 + i));
         check($sformatf("wrap_empty%0d", r), 32'(r_empty), 1);
      end

      // simultaneous write+read when full
      for (int i = 0; i < 5; i++) push(DW'(8'hA0 + i));
      w_inc = 1'b1; r_inc = 1'b1; w_data = 8'hFF;
      step();
      w_inc = 1'b0; r_inc = 1'b0;
      check("wr_full_cnt", 32'(count), 4);
      check("wr_full_ovf", 32'(overflow), 1);
      check("wr_full_head", 32'(r_data), 32'h A1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      for (int i = 1; i < 5; i++) pop("full_drain", DW'(8'hA0 + i));
      check("full_drain_empty", 32'(r_empty), 1);

      // simultaneous write+read when empty
      w_inc = 1'b1; r_inc = 1'b1; w_data = 8'h5A;
      step();
      w_inc = 1'b0; r_inc = 1'b0;
      check("wr_empty_cnt", 32'(count), 1);
      check("wr_empty_udf", 32'(underflow), 1);
      check("wr_empty_data", 32'(r_data), 32'h5A);
      pop("empty_drain", 8'h5A);
      r_inc = 1'b1; err_clr = 1'b1;
      step();
      r_inc = 1'b0; err_clr = 1'b0;
      check("udf_beats_clr", 32'(underflow), 1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      check("udf_clr", 32'(underflow), 0);

      // threshold change takes effect without a clock edge
      for (int i = 0; i < 3; i++) push(DW'(8'h30 + i));
      chk_lvl("thr3", 3);
      af_thresh = 3'd2;
      #1;
      check("af_live", 32'(almost_full), 1);
      ae_thresh = 3'd5;
      #1;
      check("ae_ge_depth", 32'(almost_empty), 1);
      af_thresh = 3'd4; ae_thresh = 3'd1;

      // flush at count 3 with a pending write, overflow kept
      push(8'h33); push(8'h34); push(8'h35);
      check("pre_flush_ovf", 32'(overflow), 1);
      pop("pre_flush_rd0", 8'h30);
      pop("pre_flush_rd1", 8'h31);
      flush = 1'b1; w_inc = 1'b1; w_data = 8'hEE;
      step();
      flush = 1'b0; w_inc = 1'b0;
      check("flush_cnt", 32'(count), 0);
      check("flush_empty", 32'(r_empty), 1);
      check("flush_ovf", 32'(overflow), 1);
      flush = 1'b1; r_inc = 1'b1;
      step();
      flush = 1'b0; r_inc = 1'b0;
      check("flush_no_udf", 32'(underflow), 0);
      push(8'h77);
      check("post_flush_data", 32'(r_data), 32'h77);

      // async reset between edges at count 2
      push(8'h78);
      check("pre_rst_cnt", 32'(count), 2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_cnt", 32'(count), 0);
      check("arst_empty", 32'(r_empty), 1);
      check("arst_ovf", 32'(overflow), 0);
      check("arst_ae", 32'(almost_empty), 1);
      #2 rst_n = 1'b1;
      step();
      check("post_rst_cnt", 32'(count), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/svc_sync_fifo_lvl.md
# svc_sync_fifo_lvl

Single-clock FWFT FIFO with arbitrary (non-power-of-two) depth, an occupancy count, runtime-programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags. Drop-in successor to the basic sync FIFO for stream buffers that need back-pressure headroom, rate monitoring, or recovery from protocol errors without a full reset.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; any integer >= 2.
- `DATA_WIDTH`, 8: width of each entry.
- `CNT_WIDTH`, $clog2(DEPTH+1): derived width of count and thresholds; not to be overridden.

Ports:
- `clk` input 1: clock; all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `flush` input 1: synchronous clear of FIFO contents.
- `w_inc` input 1: write request.
- `w_data` input DATA_WIDTH: write data.
- `w_full` output 1: FIFO holds DEPTH entries.
- `r_inc` input 1: read (pop) request.
- `r_data` output DATA_WIDTH: head entry (FWFT); don't-care while r_empty.
- `r_empty` output 1: FIFO holds 0 entries.
- `count` output CNT_WIDTH: current occupancy, 0..DEPTH.
- `af_thresh` input CNT_WIDTH: almost-full threshold.
- `ae_thresh` input CNT_WIDTH: almost-empty threshold.
- `almost_full` output 1: count >= af_thresh.
- `almost_empty` output 1: count <= ae_thresh.
- `err_clr` input 1: clears sticky error flags.
- `overflow` output 1: sticky; write attempted while full.
- `underflow` output 1: sticky; read attempted while empty.

## Operation
- State: w_addr, r_addr (0..DEPTH-1), count (0..DEPTH), overflow, underflow. Memory array is not reset.
- Accepted write: w_inc && !w_full → mem[w_addr] <= w_data, w_addr advances.
- Accepted read: r_inc && !r_empty → r_addr advances.
- Address advance: +1, wrapping from DEPTH-1 to 0 (explicit compare, not bit truncation).
- count: +1 on write-only accept, -1 on read-only accept, unchanged when both or neither are accepted.
- w_full = (count == DEPTH); r_empty = (count == 0); both decoded from the registered count.
- Simultaneous w_inc and r_inc:
  - When full: the write is rejected and overflow is set; the read is accepted; count becomes DEPTH-1.
  - When empty: the read is ignored and underflow is set; the write is accepted; count becomes 1.
  - Otherwise: both are accepted; count is unchanged.
- flush: next edge sets w_addr = r_addr = 0 and count = 0. flush has priority over w_inc/r_inc in the same cycle, and no error is flagged for requests in that cycle. flush does not touch overflow/underflow.
- overflow is set on w_inc && w_full && !flush; underflow is set on r_inc && r_empty && !flush. err_clr clears both. A set condition in the same cycle as err_clr wins.
- almost_full and almost_empty are combinational from the registered count and the threshold inputs. Thresholds may change at any time; the flags follow in the same cycle.
  - af_thresh = 0: almost_full is always 1.
  - ae_thresh >= DEPTH: almost_empty is always 1.

## Timing
- Reset (rst_n low, async): w_addr = r_addr = 0, count = 0, w_full = 0, r_empty = 1, overflow = underflow = 0, almost_empty = 1, almost_full = (af_thresh == 0). Reset deassertion is synchronised externally.
- Write-to-read latency: data written at edge N is on r_data, with r_empty = 0, after edge N (FWFT, zero added wait).
- r_data is combinational from mem[r_addr]. A pop at edge N presents the next entry after edge N.
- w_full, r_empty and count update one edge after the causing request; there is no combinational path from w_inc/r_inc to any flag.
- Error flags assert one edge after the offending request.
- Reset mid-operation: all state above returns to reset values immediately. Memory contents are undefined to the user.

## Test plan
- DEPTH=5: reset, then write 1..5 → count 5, w_full=1; write 6 → rejected, overflow=1; read five times → r_data 1,2,3,4,5; r_empty=1.
- DEPTH=5 wrap: 3 writes / 3 reads repeated 4 times with incrementing data → data order preserved across address wrap; count never exceeds 3.
- Simultaneous w_inc+r_inc when full (count 5 → 5 is illegal): count becomes 4, overflow=1. When empty: count becomes 1, underflow=1, r_data equals the written word.
- Thresholds: af_thresh=4, ae_thresh=1, fill 0→5 → almost_empty=1 at count 0..1, almost_full=1 at count 4..5; change af_thresh to 2 at count 3 → almost_full rises the same cycle.
- flush at count 3 with w_inc=1 → count 0, r_empty=1, no write, overflow unchanged; err_clr together with an underflow read → underflow stays 1.
- Async reset asserted mid-burst (count 2, between edges) → outputs take reset values before the next clock edge.
